// File: rtl/fetch_queue_unit.sv
// Fetch stage: sequential I-cache requests, QDEPTH-entry instruction queue, redirect flush, halt detection.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
  parameter int unsigned     AW       = 16,
  parameter int unsigned     IW       = 16,
  parameter int unsigned     QDEPTH   = 4,
  parameter int unsigned     PC_INC   = 2,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [3:0]      HALT_OP  = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          dec_valid,
  output logic [IW-1:0] dec_instr,
  output logic [AW-1:0] dec_pc,
  output logic [AW-1:0] dec_pc_next,
  input  logic          dec_ready,
  output logic          halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_cache_stall,
  output logic [31:0]   perf_flush
`endif
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] fetch_pc;
  logic          drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] q_pc    [QDEPTH];
  logic [IW-1:0] q_instr [QDEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic accept;

  always_comb begin
    full        = (count == CW'(QDEPTH));
    empty       = (count == '0);
    imem_req    = !rst && (state == S_REQ) && !full && !redirect_en;
    imem_addr   = fetch_pc;
    dec_valid   = !rst && !empty && !redirect_en;
    dec_instr   = q_instr[rd_ptr];
    dec_pc      = q_pc[rd_ptr];
    dec_pc_next = dec_pc + AW'(PC_INC);
    halted      = !rst && (state == S_HALT);
    // Only one request is ever in flight and it is issued only with a free slot, so push never overflows.
    push        = !rst && !redirect_en && (state == S_WAIT) && imem_rsp_valid && !drop;
    pop         = dec_valid && dec_ready;
    accept      = imem_req && imem_ready;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_en) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= redirect_pc;
      // A response still owed by the cache must be swallowed when it finally arrives.
      if ((state == S_WAIT) && !imem_rsp_valid) begin
        state <= S_WAIT;
        drop  <= 1'b1;
      end else begin
        state <= S_REQ;
        drop  <= 1'b0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case (state)
        S_REQ: begin
          if (accept) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              fetch_pc <= fetch_pc + AW'(PC_INC);
              state    <= (imem_rsp_data[IW-1 -: 4] == HALT_OP) ? S_HALT : S_REQ;
            end
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched     <= '0;
      perf_cache_stall <= '0;
      perf_flush       <= '0;
    end else begin
      if (push && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (imem_req && !imem_ready && (perf_cache_stall != '1))
        perf_cache_stall <= perf_cache_stall + 32'd1;
      if (redirect_en && (perf_flush != '1))
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
